// File: rtl/ofdm_preamble_defs.sv
// Shared definitions for the OFDM preamble inserter: register map, LEN
// field layout, reset defaults and the FSM state encoding.
package ofdm_preamble_defs;

    localparam int REG_CTRL     = 0;
    localparam int REG_LEN      = 1;
    localparam int REG_RAM_ADDR = 2;
    localparam int REG_RAM_DATA = 3;

    localparam int LEN_CP_LSB   = 16;
    localparam int LEN_CP_W     = 8;

    localparam int HALF_LEN_RST = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CP,
        ST_HALF0,
        ST_HALF1,
        ST_PAYLOAD
    } state_e;

endpackage

// File: rtl/ofdm_preamble_ram.sv
// Preamble sample store: one write port, one synchronous read port with a
// read enable so the read data holds while the output stage is stalled.
module ofdm_preamble_ram #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [2**AW];

    // Write port and registered read; contents are not reset.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/ofdm_preamble_inserter.sv
// Prepends a cyclic-prefixed, two-half preamble (read from a small RAM) to
// each input packet, then passes the packet through.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for a packet; latches settings when one arrives
// ST_CP      | reading the cyclic prefix (tail of the half)
// ST_HALF0   | reading the first copy of the half
// ST_HALF1   | reading the second copy of the half
// ST_PAYLOAD | passing input beats through until the last one
module ofdm_preamble_inserter
    import ofdm_preamble_defs::*;
#(
    parameter int SR_BASE      = 0,
    parameter int MAX_LEN_LOG2 = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready
);

    localparam int AW = MAX_LEN_LOG2;
    localparam int CW = (AW + 1 > LEN_CP_W + 1) ? AW + 1 : LEN_CP_W + 1;

    state_e                state_q, state_d, cur_phase;
    logic                  enable_q;
    logic [AW-1:0]         len_m1_q, wptr_q;
    logic [LEN_CP_W-1:0]   cp_len_q;
    logic [AW-1:0]         rd_addr_q, rd_addr_d, cnt_q, cnt_d, hl_m1_q, hl_m1_d;
    logic [AW-1:0]         cur_addr, cur_cnt, cur_hl_m1;
    logic                  s1_vld_q, s1_vld_d;
    logic                  o_tvalid_q, o_tlast_q;
    logic [31:0]           o_tdata_q, ram_rdata;
    logic                  wr_ctrl, wr_len, wr_addr, wr_data, ram_we;
    logic                  adv, issue, in_rdy;
    logic [CW-1:0]         hl_new, cp_ext, cp_eff;

    assign wr_ctrl = set_stb && (set_addr == 8'(SR_BASE + REG_CTRL));
    assign wr_len  = set_stb && (set_addr == 8'(SR_BASE + REG_LEN));
    assign wr_addr = set_stb && (set_addr == 8'(SR_BASE + REG_RAM_ADDR));
    assign wr_data = set_stb && (set_addr == 8'(SR_BASE + REG_RAM_DATA));
    // RAM contents may only change between packets.
    assign ram_we  = wr_data && (state_q == ST_IDLE);

    // Output stage can take a new sample this cycle.
    assign adv = !o_tvalid_q || o_tready;

    assign hl_new = CW'(len_m1_q) + CW'(1);
    assign cp_ext = CW'(cp_len_q);
    assign cp_eff = (cp_ext < hl_new) ? cp_ext : hl_new;

    // Settings registers and RAM write pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q <= 1'b0;
            len_m1_q <= AW'(HALF_LEN_RST - 1);
            cp_len_q <= '0;
            wptr_q   <= '0;
        end else begin
            if (wr_ctrl) enable_q <= set_data[0];
            if (wr_len) begin
                len_m1_q <= set_data[AW-1:0];
                cp_len_q <= set_data[LEN_CP_LSB +: LEN_CP_W];
            end
            if (wr_addr)     wptr_q <= set_data[AW-1:0];
            else if (ram_we) wptr_q <= wptr_q + AW'(1);
        end
    end

    // Next state and read sequencing. The IDLE cycle already issues the first
    // RAM read so the first preamble sample appears two cycles after i_tvalid.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;
        hl_m1_d   = hl_m1_q;
        cur_phase = state_q;
        cur_addr  = rd_addr_q;
        cur_cnt   = cnt_q;
        cur_hl_m1 = hl_m1_q;
        issue     = 1'b0;
        in_rdy    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_tvalid && adv) begin
                    hl_m1_d   = len_m1_q;
                    cur_hl_m1 = len_m1_q;
                    if (!enable_q) begin
                        state_d = ST_PAYLOAD;
                    end else begin
                        issue = 1'b1;
                        if (cp_eff != '0) begin
                            cur_phase = ST_CP;
                            cur_addr  = AW'(hl_new - cp_eff);
                            cur_cnt   = AW'(cp_eff - CW'(1));
                        end else begin
                            cur_phase = ST_HALF0;
                            cur_addr  = '0;
                            cur_cnt   = len_m1_q;
                        end
                    end
                end
            end
            ST_CP, ST_HALF0, ST_HALF1: issue = adv;
            ST_PAYLOAD: begin
                // The last preamble sample still in the RAM stage goes out first.
                in_rdy = adv && !s1_vld_q;
                if (in_rdy && i_tvalid && i_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (issue) begin
            if (cur_cnt == '0) begin
                rd_addr_d = '0;
                cnt_d     = cur_hl_m1;
                case (cur_phase)
                    ST_CP:    state_d = ST_HALF0;
                    ST_HALF0: state_d = ST_HALF1;
                    default:  state_d = ST_PAYLOAD;
                endcase
            end else begin
                state_d   = cur_phase;
                rd_addr_d = cur_addr + AW'(1);
                cnt_d     = cur_cnt - AW'(1);
            end
        end
        s1_vld_d = adv ? issue : s1_vld_q;
    end

    // FSM and read-sequencer registers.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            cnt_q     <= '0;
            hl_m1_q   <= '0;
            s1_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
            hl_m1_q   <= hl_m1_d;
            s1_vld_q  <= s1_vld_d;
        end
    end

    // Registered output stage: RAM sample takes priority over payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_tvalid_q <= 1'b0;
            o_tlast_q  <= 1'b0;
            o_tdata_q  <= '0;
        end else if (clear) begin
            o_tvalid_q <= 1'b0;
            o_tlast_q  <= 1'b0;
        end else if (adv) begin
            if (s1_vld_q) begin
                o_tvalid_q <= 1'b1;
                o_tlast_q  <= 1'b0;
                o_tdata_q  <= ram_rdata;
            end else if (in_rdy && i_tvalid) begin
                o_tvalid_q <= 1'b1;
                o_tlast_q  <= i_tlast;
                o_tdata_q  <= i_tdata;
            end else begin
                o_tvalid_q <= 1'b0;
            end
        end
    end

    ofdm_preamble_ram #(.AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wptr_q),
        .wdata_i (set_data),
        .re_i    (issue),
        .raddr_i (cur_addr),
        .rdata_o (ram_rdata)
    );

    assign i_tready = in_rdy;
    assign o_tvalid = o_tvalid_q;
    assign o_tlast  = o_tlast_q;
    assign o_tdata  = o_tdata_q;

endmodule

// File: doc/ofdm_preamble_inserter.md
OFDM_PREAMBLE_INSERTER -- requirements
Module: ofdm_preamble_inserter

Interface
REQ-001 SHALL have parameter SR_BASE, default 0, meaning the settings address of the first of 4 consecutive registers.
REQ-002 SHALL have parameter MAX_LEN_LOG2, default 7, meaning the preamble RAM depth is 2^MAX_LEN_LOG2 sc16 samples.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; one clock, all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous flush of datapath state.
REQ-006 SHALL have settings ports set_stb (input, 1), set_addr (input, 8) and set_data (input, 32): the settings bus.
REQ-007 SHALL have input stream i_tdata (input, 32), i_tlast (input, 1), i_tvalid (input, 1) and i_tready (output, 1): sc16 payload, I in [31:16].
REQ-008 SHALL have output stream o_tdata (output, 32), o_tlast (output, 1), o_tvalid (output, 1) and o_tready (input, 1): preamble followed by payload.

Function
REQ-009 SHALL decode registers: SR_BASE+0 CTRL[0]=enable; SR_BASE+1 LEN[MAX_LEN_LOG2-1:0]=half_len-1, LEN[23:16]=cp_len; SR_BASE+2 RAM_ADDR; SR_BASE+3 RAM_DATA.
REQ-010 SHALL, on each RAM_DATA write, store the data at the RAM_ADDR pointer and then increment the pointer modulo 2^MAX_LEN_LOG2, wrapping from 127 to 0.
REQ-011 SHALL ignore RAM_DATA writes while state is not IDLE; the pointer is not incremented in that case.
REQ-012 SHALL implement states IDLE, CP, HALF0, HALF1 and PAYLOAD.
REQ-013 SHALL, in IDLE, hold i_tready=0 and, when i_tvalid=1, latch enable, half_len and cp_eff=min(cp_len, half_len).
REQ-014 SHALL, from IDLE, go to CP if cp_eff>0, to HALF0 if cp_eff=0, and to PAYLOAD if enable=0 (bypass).
REQ-015 SHALL, in CP, emit RAM[half_len-cp_eff .. half_len-1], then go to HALF0.
REQ-016 SHALL, in HALF0 and in HALF1, each emit RAM[0 .. half_len-1] in order, so the two halves are identical.
REQ-017 SHALL drive o_tlast=0 on every preamble sample.
REQ-018 SHALL keep i_tready=0 for the whole preamble, so no payload is consumed.
REQ-019 SHALL, in PAYLOAD, pass i_tdata and i_tlast through with i_tready asserted whenever the output stage can accept.
REQ-020 SHALL return to IDLE on the accepted beat with i_tlast=1.
REQ-021 SHALL drive outputs from a registered output stage with full throughput: one sample per cycle while o_tready=1.
REQ-022 SHALL place the first preamble sample on o_tvalid exactly 2 cycles after i_tvalid is seen in IDLE (RAM read plus output register).
REQ-023 SHALL keep o_tdata and o_tlast stable while o_tvalid=1 and o_tready=0.
REQ-024 SHALL stall the preamble counter without skipping or repeating samples under o_tready backpressure.
REQ-025 SHALL treat a 1-sample burst (i_tlast on the first beat) normally: full preamble, then a single payload beat with o_tlast=1.
REQ-026 SHALL let settings writes during a burst take effect only at the next IDLE latch.
REQ-027 SHALL, on clear, go to IDLE and drop the output-stage contents (o_tvalid=0 the next cycle), retaining registers and RAM.

Reset
REQ-028 SHALL, on reset, set state=IDLE, o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=0, enable=0, half_len=64, cp_len=0 and RAM pointer=0.
REQ-029 SHALL leave RAM contents undefined after reset, not cleared.
REQ-030 SHALL abort a reset asserted mid-preamble or mid-payload without emitting further samples.

Structure
REQ-031 SHALL place register offsets, the state encoding and the LEN field positions in a shared include, ofdm_preamble_defs.
REQ-032 SHALL implement the RAM as one sub-module, ofdm_preamble_ram: 1 write port and 1 synchronous read port with 1-cycle latency.

Verification
REQ-033 SHALL cover basic insertion: RAM[i]=i for i=0..127, half_len=16, cp_len=4, enable=1, 10-sample payload -> output 12,13,14,15, 0..15, 0..15, payload; 46 beats; o_tlast only on beat 46.
REQ-034 SHALL cover bypass: enable=0, 8-sample packet -> identical 8 beats; first beat 2 cycles after input.
REQ-035 SHALL cover the clamp: cp_len=200, half_len=8 -> CP of 8 samples (0..7) followed by two halves; 24 preamble beats.
REQ-036 SHALL cover backpressure: random o_tready at 50% duty, half_len=128 -> sequence identical to o_tready=1 with no drops or duplicates.
REQ-037 SHALL cover the write guard: RAM_DATA write during HALF1 -> RAM unchanged and pointer unchanged; the same write in IDLE increments the pointer from 127 to 0.
REQ-038 SHALL cover mid-burst reset and clear: assertion in HALF0 -> o_tvalid=0 the next cycle; the next packet yields a full preamble.
